// File: rtl/calc_pkg.sv
// Shared definitions for the calculator display path: converter state encoding
// and the BCD digit constants used by the double-dabble datapath.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         BCD_W      = 4;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_ADD    = 4'd3;

  // 10^n, used by the elaboration-time digit-count check.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit pre-shift correction: values of 5 or more get +3 so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= ADJ_THRESH) begin
      dout = din + ADJ_ADD;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) that
// turns the adder result into sign plus packed BCD digits for the display.
module bin_to_bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [WIDTH-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic                      neg,
  output logic [BCD_W*DIGITS-1:0]   bcd
);

  localparam int ACC_W = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  generate
    if (WIDTH < 2) begin : g_chk_width
      $error("bin_to_bcd_seq: WIDTH must be at least 2");
    end
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_chk_digits
      $error("bin_to_bcd_seq: DIGITS too small to hold 2^WIDTH-1");
    end
  endgenerate

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       sh_reg;
  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_adj;
  logic [ACC_W-1:0]       acc_nxt;
  logic                   neg_cap;
  logic                   accept;
  logic                   last;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] m;
    m = v;
    if (SIGNED && v[WIDTH-1]) begin
      m = -v;
    end
    return m;
  endfunction

  function automatic logic is_neg(input logic signed [WIDTH-1:0] v);
    return SIGNED && v[WIDTH-1];
  endfunction

  // Operands are taken in IDLE and in the DONE cycle, never mid-conversion.
  assign accept = start && (state != SHIFT);
  assign last   = (state == SHIFT) && (cnt == CNT_W'(1));

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc[d*BCD_W +: BCD_W]),
      .dout (acc_adj[d*BCD_W +: BCD_W])
    );
  end

  assign acc_nxt = {acc_adj[ACC_W-2:0], sh_reg[WIDTH-1]};

  // Stage: shift datapath (no reset needed; always reloaded on accept)
  always_ff @(posedge clk) begin
    if (accept) begin
      sh_reg <= magnitude(bin);
      acc    <= '0;
    end else if (state == SHIFT) begin
      sh_reg <= {sh_reg[WIDTH-2:0], 1'b0};
      acc    <= acc_nxt;
    end
  end

  // Stage: control and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      neg_cap <= 1'b0;
      neg     <= 1'b0;
      bcd     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt     <= CNT_W'(WIDTH);
        neg_cap <= is_neg(bin);
      end else if (state == SHIFT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (last) begin
        bcd <= acc_nxt;
        neg <= neg_cap;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
    done = (state == DONE);
  end

endmodule
